spi_ram_arbiter: RTL and testbench



---
 rtl/spi_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - oversampled multi-port SPI slave with round-robin shared serial RAM and mailbox ring
module spi_ram_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int BYTE_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] spi_nss,
    input  logic [NUM_MASTERS-1:0] spi_sck,
    input  logic [NUM_MASTERS-1:0] spi_mosi,
    output logic [NUM_MASTERS-1:0] spi_miso,
    output logic                   ram_nss,
    output logic                   ram_sck,
    output logic                   ram_mosi,
    input  logic                   ram_miso,
    output logic [NUM_MASTERS-1:0] owner,
    output logic [NUM_MASTERS-1:0] mbox_irq
);
    localparam int CW = $clog2(BYTE_WIDTH);
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {OPCODE, STATUS, WMBOX, RMBOX, PASSTHRU, IGNORE} state_t;

    logic [NUM_MASTERS-1:0] pending, denied;
    logic [NUM_MASTERS-1:0] req_stb, rel_stb, deny_stb, undeny_stb, wr_stb, rd_stb, set_irq;
    logic [NUM_MASTERS-1:0] pt_active, sck_v, mosi_v;
    logic [BYTE_WIDTH-1:0]  mbox_v [NUM_MASTERS];
    logic [PW-1:0]          rr_ptr, grant_idx, cand;
    logic                   grant_valid, grant_ok;
    logic [NUM_MASTERS-1:0] gmask;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
        localparam int PREV = (i + NUM_MASTERS - 1) % NUM_MASTERS;

        logic [SYNC_STAGES-1:0] nss_sy, sck_sy, mosi_sy;
        logic                   nss_s, sck_s, mosi_s, sck_d, rise, fall, byte_done, data_seen, miso_q;
        logic [CW-1:0]          cnt;
        logic [BYTE_WIDTH-1:0]  shreg, snap, mbox_q, status_byte;
        logic                   req_l, rel_l, deny_l, undeny_l, wr_l, rd_l;
        state_t                 state, state_nx;

        assign nss_s     = nss_sy[SYNC_STAGES-1];
        assign sck_s     = sck_sy[SYNC_STAGES-1];
        assign mosi_s    = mosi_sy[SYNC_STAGES-1];
        assign rise      = ~nss_s & sck_s & ~sck_d;
        assign fall      = ~nss_s & ~sck_s & sck_d;
        assign byte_done = fall && (cnt == CW'(BYTE_WIDTH - 1));
        assign status_byte = {{(BYTE_WIDTH-4){1'b0}}, mbox_irq[i], denied[i], pending[i], owner[i]};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) state <= OPCODE;
            else       state <= state_nx;
        end

        // Side effects fire on opcode completion or on the first data byte only.
        always_comb begin
            state_nx = state;
            req_l    = 1'b0;
            rel_l    = 1'b0;
            deny_l   = 1'b0;
            undeny_l = 1'b0;
            wr_l     = 1'b0;
            rd_l     = 1'b0;
            if (nss_s) begin
                state_nx = OPCODE;
            end else if (byte_done && state == OPCODE) begin
                case (shreg)
                    BYTE_WIDTH'(1): state_nx = STATUS;
                    BYTE_WIDTH'(2): state_nx = WMBOX;
                    BYTE_WIDTH'(3): state_nx = RMBOX;
                    BYTE_WIDTH'(4): begin state_nx = IGNORE; req_l = ~owner[i]; end
                    BYTE_WIDTH'(5): begin state_nx = IGNORE; rel_l = 1'b1; end
                    BYTE_WIDTH'(6): begin
                        state_nx = owner[i] ? PASSTHRU : IGNORE;
                        deny_l   = ~owner[i];
                    end
                    default: state_nx = IGNORE;
                endcase
            end else if (byte_done && !data_seen) begin
                undeny_l = (state == STATUS);
                wr_l     = (state == WMBOX);
                rd_l     = (state == RMBOX);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                nss_sy    <= '1;
                sck_sy    <= '0;
                mosi_sy   <= '0;
                sck_d     <= 1'b0;
                cnt       <= '0;
                shreg     <= '0;
                snap      <= '0;
                mbox_q    <= '0;
                data_seen <= 1'b0;
                miso_q    <= 1'b0;
            end else begin
                nss_sy  <= {nss_sy[SYNC_STAGES-2:0], spi_nss[i]};
                sck_sy  <= {sck_sy[SYNC_STAGES-2:0], spi_sck[i]};
                mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], spi_mosi[i]};
                sck_d   <= sck_s;
                if (nss_s) begin
                    cnt       <= '0;
                    data_seen <= 1'b0;
                end else begin
                    if (rise) shreg <= {mosi_s, shreg[BYTE_WIDTH-1:1]};
                    if (fall) cnt <= byte_done ? '0 : cnt + 1'b1;
                    if (byte_done && state != OPCODE) data_seen <= 1'b1;
                end
                if (byte_done && state == OPCODE)
                    snap <= (shreg == BYTE_WIDTH'(1)) ? status_byte : mbox_v[PREV];
                if (wr_l) mbox_q <= shreg;
                miso_q <= (state == STATUS || state == RMBOX) ? snap[cnt] : 1'b0;
            end
        end

        assign pt_active[i]  = (state == PASSTHRU) & ~nss_s;
        assign sck_v[i]      = sck_s;
        assign mosi_v[i]     = mosi_s;
        assign spi_miso[i]   = pt_active[i] ? ram_miso : miso_q;
        assign mbox_v[i]     = mbox_q;
        assign req_stb[i]    = req_l;
        assign rel_stb[i]    = rel_l;
        assign deny_stb[i]   = deny_l;
        assign undeny_stb[i] = undeny_l;
        assign wr_stb[i]     = wr_l;
        assign rd_stb[i]     = rd_l;
        assign set_irq[i]    = wr_stb[PREV];
    end

    assign ram_nss  = ~|pt_active;
    assign ram_sck  = |(pt_active & sck_v);
    assign ram_mosi = |(pt_active & mosi_v);

    // Scan downward so the candidate closest after rr_ptr is the one kept.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            cand = PW'((int'(rr_ptr) + j) % NUM_MASTERS);
            if (pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_ok = grant_valid && (owner == '0) && ram_nss;
    assign gmask    = grant_ok ? (NUM_MASTERS'(1) << grant_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= '0;
            pending  <= '0;
            denied   <= '0;
            mbox_irq <= '0;
            rr_ptr   <= '0;
        end else begin
            owner    <= (|(rel_stb & owner)) ? '0 : (owner | gmask);
            pending  <= (pending | req_stb) & ~(rel_stb & ~owner) & ~gmask;
            denied   <= (denied | deny_stb) & ~undeny_stb;
            mbox_irq <= (mbox_irq & ~rd_stb) | set_irq;
            if (grant_ok)
                rr_ptr <= (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - directed self-checking bench for spi_ram_arbiter with two ports
module tb_spi_ram_arbiter;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] spi_nss = 2'b11;
    logic [1:0] spi_sck = 2'b00;
    logic [1:0] spi_mosi = 2'b00;
    logic [1:0] spi_miso;
    logic       ram_nss, ram_sck, ram_mosi, ram_miso;
    logic [1:0] owner, mbox_irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] r0, r1;

    // Serial RAM model: logs mosi on rising sck, answers with ram_pat LSB first.
    logic [5:0]  ram_cnt = '0;
    logic [31:0] ram_log = '0;
    logic [7:0]  ram_pat = 8'h5A;
    assign ram_miso = ram_pat[ram_cnt[2:0]];

    always @(posedge ram_sck or negedge ram_nss) begin
        if (ram_sck) begin
            ram_cnt <= ram_cnt + 6'd1;
            ram_log <= {ram_mosi, ram_log[31:1]};
        end else begin
            ram_cnt <= '0;
            ram_log <= '0;
        end
    end

    spi_ram_arbiter #(.NUM_MASTERS(2), .BYTE_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_nss(spi_nss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .ram_nss(ram_nss), .ram_sck(ram_sck), .ram_mosi(ram_mosi), .ram_miso(ram_miso),
        .owner(owner), .mbox_irq(mbox_irq)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin(input logic [1:0] m);
        spi_nss = spi_nss & ~m;
        wait_clks(HALF);
    endtask

    task automatic spi_byte(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1,
                            output logic [7:0] q0, output logic [7:0] q1);
        for (int b = 0; b < 8; b++) begin
            if (m[0]) spi_mosi[0] = d0[b];
            if (m[1]) spi_mosi[1] = d1[b];
            wait_clks(HALF);
            q0[b] = spi_miso[0];
            q1[b] = spi_miso[1];
            spi_sck = spi_sck | m;
            wait_clks(HALF);
            spi_sck = spi_sck & ~m;
        end
    endtask

    task automatic spi_end(input logic [1:0] m);
        wait_clks(HALF);
        spi_nss  = spi_nss | m;
        spi_mosi = spi_mosi & ~m;
        wait_clks(8);
    endtask

    task automatic xact(input logic [1:0] m, input logic [7:0] op, input logic [7:0] data,
                        output logic [7:0] q0, output logic [7:0] q1);
        logic [7:0] t0, t1;
        spi_begin(m);
        spi_byte(m, op, op, t0, t1);
        spi_byte(m, data, data, q0, q1);
        spi_end(m);
    endtask

    task automatic cmd(input logic [1:0] m, input logic [7:0] op);
        logic [7:0] t0, t1;
        spi_begin(m);
        spi_byte(m, op, op, t0, t1);
        spi_end(m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(3);
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL reset_owner: got %b want 00", owner); end
        n_cmp++; if (ram_nss !== 1'b1) begin n_bad++; $display("FAIL reset_ram_nss: got %b want 1", ram_nss); end
        n_cmp++; if (ram_sck !== 1'b0) begin n_bad++; $display("FAIL reset_ram_sck: got %b want 0", ram_sck); end
        n_cmp++; if (ram_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_ram_mosi: got %b want 0", ram_mosi); end
        n_cmp++; if (spi_miso !== 2'b00) begin n_bad++; $display("FAIL reset_miso: got %b want 00", spi_miso); end
        n_cmp++; if (mbox_irq !== 2'b00) begin n_bad++; $display("FAIL reset_irq: got %b want 00", mbox_irq); end
        reset = 1'b0;
        wait_clks(2);
        xact(2'b01, 8'h01, 8'h00, r0, r1);
        n_cmp++; if (r0 !== 8'h00) begin n_bad++; $display("FAIL first_status: got %h want 00", r0); end
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL first_owner: got %b want 00", owner); end
        n_cmp++; if (ram_nss !== 1'b1) begin n_bad++; $display("FAIL first_ram_nss: got %b want 1", ram_nss); end
    endtask

    task automatic test_passthru();
        logic [7:0] tx [4];
        tx = '{8'h03, 8'h00, 8'h10, 8'hFF};
        cmd(2'b01, 8'h04);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL req_grant: got %b want 01", owner); end
        spi_begin(2'b01);
        spi_byte(2'b01, 8'h06, 8'h00, r0, r1);
        n_cmp++; if (r0 !== 8'h00) begin n_bad++; $display("FAIL pt_opcode_miso: got %h want 00", r0); end
        wait_clks(5);
        n_cmp++; if (ram_nss !== 1'b0) begin n_bad++; $display("FAIL pt_ram_nss_low: got %b want 0", ram_nss); end
        n_cmp++; if (ram_sck !== 1'b0) begin n_bad++; $display("FAIL pt_ram_sck_idle: got %b want 0", ram_sck); end
        n_cmp++; if (spi_miso[1] !== 1'b0) begin n_bad++; $display("FAIL pt_other_miso: got %b want 0", spi_miso[1]); end
        for (int k = 0; k < 4; k++) begin
            spi_byte(2'b01, tx[k], 8'h00, r0, r1);
            n_cmp++; if (r0 !== 8'h5A) begin n_bad++; $display("FAIL pt_miso_byte%0d: got %h want 5a", k, r0); end
        end
        n_cmp++; if (ram_cnt !== 6'd32) begin n_bad++; $display("FAIL pt_ram_clocks: got %0d want 32", ram_cnt); end
        n_cmp++; if (ram_log !== 32'hFF100003) begin n_bad++; $display("FAIL pt_ram_data: got %h want ff100003", ram_log); end
        wait_clks(HALF);
        spi_nss[0] = 1'b1;
        wait_clks(1);
        n_cmp++; if (ram_nss !== 1'b0) begin n_bad++; $display("FAIL pt_nss_lag: got %b want 0", ram_nss); end
        wait_clks(1);
        n_cmp++; if (ram_nss !== 1'b1) begin n_bad++; $display("FAIL pt_nss_rise: got %b want 1", ram_nss); end
        spi_mosi[0] = 1'b0;
        wait_clks(8);
    endtask

    task automatic test_denied();
        ram_pat = 8'hFF;
        spi_begin(2'b10);
        spi_byte(2'b10, 8'h00, 8'h06, r0, r1);
        wait_clks(5);
        n_cmp++; if (ram_nss !== 1'b1) begin n_bad++; $display("FAIL deny_ram_nss: got %b want 1", ram_nss); end
        spi_byte(2'b10, 8'h00, 8'hFF, r0, r1);
        n_cmp++; if (r1 !== 8'h00) begin n_bad++; $display("FAIL deny_miso: got %h want 00", r1); end
        n_cmp++; if (ram_sck !== 1'b0) begin n_bad++; $display("FAIL deny_ram_sck: got %b want 0", ram_sck); end
        spi_end(2'b10);
        n_cmp++; if (ram_cnt !== 6'd32) begin n_bad++; $display("FAIL deny_ram_untouched: got %0d want 32", ram_cnt); end
        ram_pat = 8'h5A;
        xact(2'b10, 8'h01, 8'h00, r0, r1);
        n_cmp++; if (r1 !== 8'h04) begin n_bad++; $display("FAIL deny_status: got %h want 04", r1); end
        xact(2'b10, 8'h01, 8'h00, r0, r1);
        n_cmp++; if (r1 !== 8'h00) begin n_bad++; $display("FAIL deny_cleared: got %h want 00", r1); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cmd(2'b11, 8'h04);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL rr_simul_req: got %b want 01", owner); end
        xact(2'b10, 8'h01, 8'h00, r0, r1);
        n_cmp++; if (r1 !== 8'h02) begin n_bad++; $display("FAIL rr_pending_status: got %h want 02", r1); end
        cmd(2'b01, 8'h05);
        n_cmp++; if (owner !== 2'b10) begin n_bad++; $display("FAIL rr_handover: got %b want 10", owner); end
        cmd(2'b10, 8'h05);
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL rr_free: got %b want 00", owner); end
        cmd(2'b01, 8'h04);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL rr_solo_p0: got %b want 01", owner); end
        cmd(2'b01, 8'h05);
        cmd(2'b11, 8'h04);
        n_cmp++; if (owner !== 2'b10) begin n_bad++; $display("FAIL rr_rotate: got %b want 10", owner); end
        cmd(2'b10, 8'h05);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL rr_waiting_p0: got %b want 01", owner); end
        cmd(2'b01, 8'h05);
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL rr_all_free: got %b want 00", owner); end
    endtask

    task automatic test_mailbox();
        xact(2'b01, 8'h02, 8'hA5, r0, r1);
        n_cmp++; if (mbox_irq !== 2'b10) begin n_bad++; $display("FAIL mb_irq_set: got %b want 10", mbox_irq); end
        xact(2'b10, 8'h01, 8'h00, r0, r1);
        n_cmp++; if (r1 !== 8'h08) begin n_bad++; $display("FAIL mb_status_irq: got %h want 08", r1); end
        xact(2'b10, 8'h03, 8'h00, r0, r1);
        n_cmp++; if (r1 !== 8'hA5) begin n_bad++; $display("FAIL mb_read: got %h want a5", r1); end
        n_cmp++; if (mbox_irq !== 2'b00) begin n_bad++; $display("FAIL mb_irq_clr: got %b want 00", mbox_irq); end
        xact(2'b10, 8'h02, 8'h3C, r0, r1);
        n_cmp++; if (mbox_irq !== 2'b01) begin n_bad++; $display("FAIL mb_irq_wrap: got %b want 01", mbox_irq); end
        xact(2'b01, 8'h03, 8'h00, r0, r1);
        n_cmp++; if (r0 !== 8'h3C) begin n_bad++; $display("FAIL mb_read_wrap: got %h want 3c", r0); end
    endtask

    task automatic test_reset_mid_passthru();
        cmd(2'b01, 8'h04);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL rm_grant: got %b want 01", owner); end
        spi_begin(2'b01);
        spi_byte(2'b01, 8'h06, 8'h00, r0, r1);
        wait_clks(5);
        n_cmp++; if (ram_nss !== 1'b0) begin n_bad++; $display("FAIL rm_pt_active: got %b want 0", ram_nss); end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (ram_nss !== 1'b1) begin n_bad++; $display("FAIL rm_async_nss: got %b want 1", ram_nss); end
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL rm_owner: got %b want 00", owner); end
        wait_clks(1);
        spi_nss[0] = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        xact(2'b10, 8'h03, 8'h00, r0, r1);
        n_cmp++; if (r1 !== 8'h00) begin n_bad++; $display("FAIL rm_mbox0_clr: got %h want 00", r1); end
        xact(2'b01, 8'h03, 8'h00, r0, r1);
        n_cmp++; if (r0 !== 8'h00) begin n_bad++; $display("FAIL rm_mbox1_clr: got %h want 00", r0); end
        xact(2'b01, 8'h01, 8'h00, r0, r1);
        n_cmp++; if (r0 !== 8'h00) begin n_bad++; $display("FAIL rm_status: got %h want 00", r0); end
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_denied();
        test_round_robin();
        test_mailbox();
        test_reset_mid_passthru();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
